// File: rtl/div_pkg.sv
// Shared constants for the bus-mapped divider peripheral:
// register offsets, CTRL/STATUS bit positions and FSM encoding.
package div_pkg;

    localparam int ADDR_DV    = 'h04;
    localparam int ADDR_DR    = 'h08;
    localparam int ADDR_CTRL  = 'h0C;
    localparam int ADDR_Q     = 'h10;
    localparam int ADDR_STAT  = 'h14;
    localparam int ADDR_REM   = 'h18;
    localparam int ADDR_IRQEN = 'h1C;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLR   = 1;

    localparam int ST_DONE = 0;
    localparam int ST_BUSY = 1;
    localparam int ST_DZ   = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_core.sv
// Restoring divider core: latches operands on load, one quotient bit
// per clock MSB first, then a single-cycle FIN state.
// Ports: CLK, reset_n (async, active low), load, dv, dr ->
//        busy, fin (one-cycle pulse), q, rem, dz.
module div_core
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] dv,
    input  logic [WIDTH-1:0] dr,
    output logic             busy,
    output logic             fin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rem,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] dr_l;
    logic [CNT_W-1:0] cnt;
    logic             dz_r;
    logic [WIDTH:0]   diff;
    logic             ge;

    // Trial subtraction on the WIDTH+1 bit shifted partial remainder;
    // a clear borrow bit means the divisor fits.
    always_comb begin
        diff = {prem, sh[WIDTH-1]} - {1'b0, dr_l};
        ge   = ~diff[WIDTH];
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            sh    <= '0;
            prem  <= '0;
            dr_l  <= '0;
            cnt   <= '0;
            dz_r  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (load) begin
                        dr_l <= dr;
                        cnt  <= CNT_W'(WIDTH);
                        if (dr == '0) begin
                            // Result is known: all-ones quotient, dividend as remainder
                            sh    <= '1;
                            prem  <= dv;
                            dz_r  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            // sh holds the dividend and collects quotient bits
                            sh    <= dv;
                            prem  <= '0;
                            dz_r  <= 1'b0;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    prem <= ge ? diff[WIDTH-1:0]
                               : {prem[WIDTH-2:0], sh[WIDTH-1]};
                    sh   <= {sh[WIDTH-2:0], ge};
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign fin  = (state == S_FIN);
    assign q    = sh;
    assign rem  = prem;
    assign dz   = dz_r;

endmodule

// File: rtl/periferico_divisor_param.sv
// Bus-mapped unsigned divider peripheral: bus registers, status, read mux.
// Ports: CLK, reset_n, cs, addr, rd, wr, d_in, d_out, irq. Optional IRQ_EN
// register and done interrupt when DIV_IRQ_EN is defined.
module periferico_divisor_param
    import div_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              cs,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic [WIDTH-1:0]  d_in,
    output logic [WIDTH-1:0]  d_out,
    output logic              irq
);

    logic [WIDTH-1:0] dv_r;
    logic [WIDTH-1:0] dr_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] rem_r;
    logic             done_r;
    logic             dz_r;
    logic [WIDTH-1:0] rdata;

    logic             busy;
    logic             fin;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] c_rem;
    logic             c_dz;

    logic wr_en;
    logic rd_en;
    logic sel_dv;
    logic sel_dr;
    logic sel_ctrl;
    logic sel_q;
    logic sel_st;
    logic sel_rem;
    logic start_acc;
    logic clr_acc;

    assign wr_en    = cs & wr;
    assign rd_en    = cs & rd;
    assign sel_dv   = (addr == ADDR_W'(ADDR_DV));
    assign sel_dr   = (addr == ADDR_W'(ADDR_DR));
    assign sel_ctrl = (addr == ADDR_W'(ADDR_CTRL));
    assign sel_q    = (addr == ADDR_W'(ADDR_Q));
    assign sel_st   = (addr == ADDR_W'(ADDR_STAT));
    assign sel_rem  = (addr == ADDR_W'(ADDR_REM));

    // Control strobes only act while idle; START outranks CLR_DONE.
    assign start_acc = wr_en & sel_ctrl & d_in[CTRL_START] & ~busy;
    assign clr_acc   = wr_en & sel_ctrl & d_in[CTRL_CLR] & ~busy;

    div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .CLK     (CLK),
        .reset_n (reset_n),
        .load    (start_acc),
        .dv      (dv_r),
        .dr      (dr_r),
        .busy    (busy),
        .fin     (fin),
        .q       (c_q),
        .rem     (c_rem),
        .dz      (c_dz)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            dv_r   <= '0;
            dr_r   <= '0;
            q_r    <= '0;
            rem_r  <= '0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            if (wr_en && sel_dv) begin
                dv_r <= d_in;
            end
            if (wr_en && sel_dr) begin
                dr_r <= d_in;
            end
            if (fin) begin
                q_r   <= c_q;
                rem_r <= c_rem;
            end
            // fin only occurs while busy, start/clr only while idle
            if (start_acc) begin
                done_r <= 1'b0;
                dz_r   <= 1'b0;
            end else if (fin) begin
                done_r <= 1'b1;
                dz_r   <= c_dz;
            end else if (clr_acc) begin
                done_r <= 1'b0;
            end
        end
    end

`ifdef DIV_IRQ_EN
    logic irq_en;
    logic sel_irq;

    assign sel_irq = (addr == ADDR_W'(ADDR_IRQEN));

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
        end else if (wr_en && sel_irq) begin
            irq_en <= d_in[0];
        end
    end

    assign irq = done_r & irq_en;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_dv:  rdata = dv_r;
            sel_dr:  rdata = dr_r;
            sel_q:   rdata = q_r;
            sel_rem: rdata = rem_r;
            sel_st: begin
                rdata[ST_DONE] = done_r;
                rdata[ST_BUSY] = busy;
                rdata[ST_DZ]   = dz_r;
            end
`ifdef DIV_IRQ_EN
            sel_irq: rdata[0] = irq_en;
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            d_out <= '0;
        end else if (rd_en) begin
            d_out <= rdata;
        end
    end

endmodule
